trap_ctrl: RTL

// - Machine-mode trap controller; consumes trap_dispatch outputs (trap_req/cause/tval) and the pc of the faulting instruction.
// - Owns the M-mode trap CSRs mstatus, mtvec, mscratch, mepc, mcause and mtval.
// - Sequences trap entry and MRET return over two cycles each: flush, CSR update, PC redirect to fetch.
// - Exceptions only; no interrupt sources in this block.

---
 rtl/trap_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller.
// Owns mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause and mtval. It sequences
// synchronous exception entry and MRET return as a flush cycle followed by one
// redirect cycle, and serves Zicsr reads/writes of the six owned CSRs.
// i_trap_cause carries the 4-bit trap_cause_t exception code from trap_dispatch.
module trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_trap_req,
  input  logic [3:0]      i_trap_cause,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_hit,
  output logic            o_flush,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_busy
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t state;

  // architectural CSR state
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;

  // trap information captured in the flush cycle, consumed in ST_ENTER
  logic [XLEN-1:0] lat_pc;
  logic [3:0]      lat_cause;
  logic [XLEN-1:0] lat_tval;

  logic in_run;
  logic take_trap;
  logic take_mret;
  logic csr_wr;

  // Trap wins over MRET; a faulting instruction's CSR write is dropped, and
  // nothing is accepted while a sequence is in flight.
  assign in_run    = (state == ST_RUN);
  assign take_trap = in_run && i_trap_req;
  assign take_mret = in_run && !i_trap_req && i_mret;
  assign csr_wr    = in_run && !i_trap_req && i_csr_we;

  // Sequencer: one redirect cycle after each accepted trap or MRET
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_RUN;
      o_busy     <= 1'b0;
      o_redirect <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (take_trap) begin
            state      <= ST_ENTER;
            o_busy     <= 1'b1;
            o_redirect <= 1'b1;
          end else if (take_mret) begin
            state      <= ST_RETURN;
            o_busy     <= 1'b1;
            o_redirect <= 1'b1;
          end else begin
            o_busy     <= 1'b0;
            o_redirect <= 1'b0;
          end
        end
        ST_ENTER, ST_RETURN: begin
          state      <= ST_RUN;
          o_busy     <= 1'b0;
          o_redirect <= 1'b0;
        end
        default: begin
          state      <= ST_RUN;
          o_busy     <= 1'b0;
          o_redirect <= 1'b0;
        end
      endcase
    end
  end

  // Capture the faulting pc, cause and tval when a trap is accepted
  always_ff @(posedge i_clk) begin
    if (take_trap) begin
      lat_pc    <= i_pc;
      lat_cause <= i_trap_cause;
      lat_tval  <= i_trap_tval;
    end
  end

  // CSR state: software writes in ST_RUN, hardware updates in ENTER/RETURN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else begin
      if (csr_wr) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            mie  <= i_csr_wdata[3];
            mpie <= i_csr_wdata[7];
          end
          CSR_MTVEC:    mtvec    <= {i_csr_wdata[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch <= i_csr_wdata;
          CSR_MEPC:     mepc     <= {i_csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= i_csr_wdata;
          CSR_MTVAL:    mtval    <= i_csr_wdata;
          default: ;
        endcase
      end
      if (state == ST_ENTER) begin
        mepc   <= {lat_pc[XLEN-1:2], 2'b00};
        mcause <= {{(XLEN-4){1'b0}}, lat_cause};
        mtval  <= lat_tval;
        mpie   <= mie;
        mie    <= 1'b0;
      end
      if (state == ST_RETURN) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  // Flush covers the accepting cycle and the redirect cycle; the return target
  // is read live so an MRET issued alongside an mepc write uses the new value.
  always_comb begin
    o_flush       = take_trap || take_mret || !in_run;
    o_redirect_pc = '0;
    case (state)
      ST_ENTER:  o_redirect_pc = {mtvec[XLEN-1:2], 2'b00};
      ST_RETURN: o_redirect_pc = mepc;
      default:   o_redirect_pc = '0;
    endcase
  end

  // CSR read mux: register state at the start of the cycle, MPP fixed at M
  always_comb begin
    o_csr_hit   = 1'b1;
    o_csr_rdata = '0;
    case (i_csr_addr)
      CSR_MSTATUS: begin
        o_csr_rdata[12:11] = 2'b11;
        o_csr_rdata[7]     = mpie;
        o_csr_rdata[3]     = mie;
      end
      CSR_MTVEC:    o_csr_rdata = mtvec;
      CSR_MSCRATCH: o_csr_rdata = mscratch;
      CSR_MEPC:     o_csr_rdata = mepc;
      CSR_MCAUSE:   o_csr_rdata = mcause;
      CSR_MTVAL:    o_csr_rdata = mtval;
      default: begin
        o_csr_hit   = 1'b0;
        o_csr_rdata = '0;
      end
    endcase
  end

endmodule
